cpu_trace_buffer: RTL and testbench

//  Synthesisable trace unit for the multi-cycle 8085 cores; replaces the per-cycle $display dump.

---
 rtl/cpu_trace_pkg.sv | 20 ++
 rtl/cpu_trace_buffer_if.sv | 13 +
 rtl/trace_ram.sv | 34 +++
 rtl/cpu_trace_buffer.sv | 185 ++++++++++++++++++
 tb/tb_cpu_trace_buffer.sv | 258 +++++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_trace_pkg.sv
// Shared definitions for the 8085 trace buffer: FSM encoding and record field offsets.
// Records are packed {pc, acc, cy, z} with z in bit 0.
package cpu_trace_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_POST  = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam int Z_BIT   = 0;
  localparam int CY_BIT  = 1;
  localparam int ACC_LSB = 2;

  function automatic int pc_lsb(input int data_w);
    return 2 + data_w;
  endfunction

endpackage

// File: rtl/cpu_trace_buffer_if.sv
// Readout port of the trace buffer: one record per rd_valid & rd_ready, rd_last on the final one.
// The source holds rd_data/rd_last stable while stalled.
interface cpu_trace_buffer_if #(
  parameter int W = 26
);
  logic         rd_valid;
  logic         rd_ready;
  logic         rd_last;
  logic [W-1:0] rd_data;

  modport master (output rd_valid, output rd_data, output rd_last, input rd_ready);
  modport slave  (input rd_valid, input rd_data, input rd_last, output rd_ready);
endinterface

// File: rtl/trace_ram.sv
// DEPTH x W simple dual-port record store; write and read both take effect on the clock edge.
// Read data is held when re is low, so the readout can stall on it directly.
module trace_ram #(
  parameter int DEPTH = 16,
  parameter int W     = 26,
  parameter int AW    = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);

  logic [W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/cpu_trace_buffer.sv
// PC-triggered circular trace of {pc, acc, cy, z}; freezes POST_SAMPLES records after the trigger,
// then streams oldest-first with first rd_valid one cycle after DONE entry. Optional: TRACE_CHANGE_ONLY_EN.
module cpu_trace_buffer
  import cpu_trace_pkg::*;
#(
  parameter int ADDR_W       = 16,
  parameter int DATA_W       = 8,
  parameter int DEPTH        = 16,
  parameter int POST_SAMPLES = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     arm,
  input  logic                     trig_en,
  input  logic [ADDR_W-1:0]        trig_pc,
  input  logic                     sample_en,
  input  logic [ADDR_W-1:0]        pc,
  input  logic [DATA_W-1:0]        acc,
  input  logic                     cy,
  input  logic                     z,
  cpu_trace_buffer_if.master       rd,
  output logic                     triggered,
  output logic [1:0]               state,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int REC_W  = ADDR_W + DATA_W + 2;
  localparam int PW     = $clog2(DEPTH);
  localparam int CW     = PW + 1;
  localparam int PC_LSB = pc_lsb(DATA_W);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [PW-1:0] POST_C  = PW'(POST_SAMPLES);

  state_t           st_q, st_d;
  logic [PW-1:0]    wr_ptr, rd_ptr, rd_start, post_cnt, ram_raddr;
  logic [CW-1:0]    rd_idx;
  logic             rd_started, rd_valid_q, rd_last_q;
  logic [REC_W-1:0] rec, ram_q;
  logic             capturing, trig_hit, wr_en, xfer, restart, ram_re;

  always_comb begin
    rec                      = '0;
    rec[Z_BIT]               = z;
    rec[CY_BIT]              = cy;
    rec[ACC_LSB +: DATA_W]   = acc;
    rec[PC_LSB +: ADDR_W]    = pc;
  end

  assign capturing = (st_q == ST_ARMED) || (st_q == ST_POST);
  assign trig_hit  = (st_q == ST_ARMED) && sample_en && trig_en && (pc == trig_pc);
  assign xfer      = rd_valid_q && rd.rd_ready;
  assign restart   = arm && ((st_q == ST_IDLE) || (st_q == ST_DONE));
  // Once the buffer has wrapped, the oldest record sits where the next write would go.
  assign rd_start  = (count == DEPTH_C) ? wr_ptr : '0;

`ifdef TRACE_CHANGE_ONLY_EN
  logic [REC_W-1:0] last_rec;
  logic             have_last;

  assign wr_en = capturing && sample_en && (!have_last || (rec != last_rec) || trig_hit);

  always_ff @(posedge clk) begin
    if (reset) begin
      last_rec  <= '0;
      have_last <= 1'b0;
    end else if (restart) begin
      have_last <= 1'b0;
    end else if (wr_en) begin
      last_rec  <= rec;
      have_last <= 1'b1;
    end
  end
`else
  assign wr_en = capturing && sample_en;
`endif

  always_comb begin
    st_d      = st_q;
    ram_re    = 1'b0;
    ram_raddr = rd_ptr;
    case (st_q)
      ST_IDLE: begin
        if (arm) st_d = ST_ARMED;
      end
      ST_ARMED: begin
        if (trig_hit) st_d = (POST_SAMPLES == 0) ? ST_DONE : ST_POST;
      end
      ST_POST: begin
        if (wr_en && (post_cnt == PW'(1))) st_d = ST_DONE;
      end
      ST_DONE: begin
        if (arm) begin
          st_d = ST_ARMED;
        end else if (!rd_started) begin
          ram_re    = 1'b1;
          ram_raddr = rd_start;
        end else if (xfer) begin
          if (rd_last_q) st_d = ST_IDLE;
          else           ram_re = 1'b1;
        end
      end
      default: st_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      st_q       <= ST_IDLE;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      post_cnt   <= '0;
      rd_idx     <= '0;
      rd_started <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_last_q  <= 1'b0;
      triggered  <= 1'b0;
    end else begin
      st_q <= st_d;

      if (restart) begin
        wr_ptr     <= '0;
        count      <= '0;
        triggered  <= 1'b0;
        rd_started <= 1'b0;
        rd_valid_q <= 1'b0;
        rd_last_q  <= 1'b0;
      end

      if (wr_en) begin
        wr_ptr <= wr_ptr + PW'(1);
        if (count != DEPTH_C) count <= count + CW'(1);
      end

      if (trig_hit) begin
        triggered <= 1'b1;
        post_cnt  <= POST_C;
      end else if ((st_q == ST_POST) && wr_en) begin
        post_cnt <= post_cnt - PW'(1);
      end

      // rd_ptr always points at the record to fetch after the one being presented.
      if ((st_q == ST_DONE) && !arm) begin
        if (!rd_started) begin
          rd_started <= 1'b1;
          rd_valid_q <= 1'b1;
          rd_ptr     <= rd_start + PW'(1);
          rd_idx     <= CW'(1);
          rd_last_q  <= (count == CW'(1));
        end else if (xfer) begin
          if (rd_last_q) begin
            rd_started <= 1'b0;
            rd_valid_q <= 1'b0;
            rd_last_q  <= 1'b0;
          end else begin
            rd_ptr    <= rd_ptr + PW'(1);
            rd_idx    <= rd_idx + CW'(1);
            rd_last_q <= ((rd_idx + CW'(1)) == count);
          end
        end
      end
    end
  end

  trace_ram #(
    .DEPTH (DEPTH),
    .W     (REC_W),
    .AW    (PW)
  ) u_ram (
    .clk   (clk),
    .reset (reset),
    .we    (wr_en),
    .waddr (wr_ptr),
    .wdata (rec),
    .re    (ram_re),
    .raddr (ram_raddr),
    .rdata (ram_q)
  );

  assign rd.rd_valid = rd_valid_q;
  assign rd.rd_last  = rd_last_q;
  assign rd.rd_data  = ram_q;
  assign state       = st_q;

endmodule

// File: tb/tb_cpu_trace_buffer.sv
// Scoreboard bench for cpu_trace_buffer (DEPTH=8, POST_SAMPLES=3): directed captures push expected
// records, a negedge monitor pops and compares on every readout transfer and checks stall stability.
module tb_cpu_trace_buffer;

  localparam int AW = 16;
  localparam int DW = 8;
  localparam int RW = AW + DW + 2;

  typedef struct packed {
    logic [RW-1:0] d;
    logic          last;
  } exp_t;

  logic          clk = 1'b0;
  logic          reset, arm, trig_en, sample_en, cy, z;
  logic [AW-1:0] trig_pc, pc;
  logic [DW-1:0] acc;
  logic          triggered;
  logic [1:0]    state;
  logic [3:0]    count;

  cpu_trace_buffer_if #(.W(RW)) rd_if ();

  cpu_trace_buffer #(
    .ADDR_W(AW), .DATA_W(DW), .DEPTH(8), .POST_SAMPLES(3)
  ) dut (
    .clk(clk), .reset(reset), .arm(arm), .trig_en(trig_en), .trig_pc(trig_pc),
    .sample_en(sample_en), .pc(pc), .acc(acc), .cy(cy), .z(z),
    .rd(rd_if), .triggered(triggered), .state(state), .count(count)
  );

  always #5 clk = ~clk;

  int   n_checks = 0;
  int   n_fail   = 0;
  int   xfers    = 0;
  exp_t q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] acc_of(input int p);
    logic [7:0] v;
    v = p[7:0] ^ 8'h5A;
    return v;
  endfunction

  function automatic logic [RW-1:0] mk(input int p);
    return {p[15:0], acc_of(p), p[0], p[1]};
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_arm();
    arm = 1'b1;
    cyc();
    arm = 1'b0;
  endtask

  task automatic feed(input int lo, input int hi);
    for (int p = lo; p <= hi; p++) begin
      sample_en = 1'b1;
      pc  = p[15:0];
      acc = acc_of(p);
      cy  = p[0];
      z   = p[1];
      cyc();
    end
    sample_en = 1'b0;
  endtask

  task automatic capture(input int tpc, input int last_pc);
    trig_en = 1'b1;
    trig_pc = tpc[15:0];
    do_arm();
    feed(0, last_pc);
  endtask

  task automatic push_range(input int lo, input int hi);
    exp_t e;
    for (int p = lo; p <= hi; p++) begin
      e.d    = mk(p);
      e.last = (p == hi);
      q.push_back(e);
    end
  endtask

  task automatic readout(input bit toggle, input int n_exp);
    int i;
    xfers = 0;
    rd_if.rd_ready = 1'b1;
    i = 0;
    while (state != 2'd0 && i < 64) begin
      if (toggle) rd_if.rd_ready = ~rd_if.rd_ready;
      cyc();
      i++;
    end
    chk("readout_idle", {30'd0, state}, 32'd0);
    chk("readout_rd_valid_low", {31'd0, rd_if.rd_valid}, 32'd0);
    chk("readout_xfers", xfers, n_exp);
    chk("readout_queue_empty", q.size(), 32'd0);
    rd_if.rd_ready = 1'b0;
  endtask

  task automatic scenario2(input bit toggle);
    capture(10, 13);
    chk("s2_state_done", {30'd0, state}, 32'd3);
    chk("s2_count", {28'd0, count}, 32'd8);
    chk("s2_triggered", {31'd0, triggered}, 32'd1);
    push_range(6, 13);
    readout(toggle, 8);
  endtask

  // Monitor: outputs sampled on the falling edge, a transfer completes at the next rising edge.
  initial begin
    logic          stall;
    logic [RW-1:0] held_d;
    logic          held_l;
    exp_t          e;
    stall = 1'b0;
    forever begin
      @(negedge clk);
      if (reset) begin
        stall = 1'b0;
      end else begin
        if (stall && rd_if.rd_valid) begin
          chk("stall_data_stable", {6'd0, rd_if.rd_data}, {6'd0, held_d});
          chk("stall_last_stable", {31'd0, rd_if.rd_last}, {31'd0, held_l});
        end
        if (rd_if.rd_valid && rd_if.rd_ready) begin
          stall = 1'b0;
          xfers++;
          if (q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL rd_unexpected: got record %0h, expected no transfer", rd_if.rd_data);
          end else begin
            e = q.pop_front();
            chk("rd_data", {6'd0, rd_if.rd_data}, {6'd0, e.d});
            chk("rd_last", {31'd0, rd_if.rd_last}, {31'd0, e.last});
          end
        end else if (rd_if.rd_valid) begin
          stall  = 1'b1;
          held_d = rd_if.rd_data;
          held_l = rd_if.rd_last;
        end else begin
          stall = 1'b0;
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; arm = 1'b0; trig_en = 1'b0; trig_pc = '0; sample_en = 1'b0;
    pc = '0; acc = '0; cy = 1'b0; z = 1'b0; rd_if.rd_ready = 1'b0;
    repeat (2) cyc();
    chk("rst_state", {30'd0, state}, 32'd0);
    chk("rst_count", {28'd0, count}, 32'd0);
    chk("rst_triggered", {31'd0, triggered}, 32'd0);
    chk("rst_rd_valid", {31'd0, rd_if.rd_valid}, 32'd0);
    chk("rst_rd_last", {31'd0, rd_if.rd_last}, 32'd0);
    chk("rst_rd_data", {6'd0, rd_if.rd_data}, 32'd0);
    reset = 1'b0;
    cyc();

    // 1: reset while DONE is presenting data
    capture(10, 13);
    chk("s1_state_done", {30'd0, state}, 32'd3);
    repeat (2) cyc();
    chk("s1_rd_valid", {31'd0, rd_if.rd_valid}, 32'd1);
    reset = 1'b1;
    repeat (2) cyc();
    reset = 1'b0;
    chk("s1_state", {30'd0, state}, 32'd0);
    chk("s1_rd_valid_low", {31'd0, rd_if.rd_valid}, 32'd0);
    chk("s1_count", {28'd0, count}, 32'd0);
    chk("s1_triggered", {31'd0, triggered}, 32'd0);

    // 2: wrapped capture, continuous readout
    scenario2(1'b0);

    // 3: early trigger, buffer not wrapped
    capture(2, 5);
    chk("s3_state_done", {30'd0, state}, 32'd3);
    chk("s3_count", {28'd0, count}, 32'd6);
    push_range(0, 5);
    readout(1'b0, 6);

    // 4: readout with rd_ready toggling
    scenario2(1'b1);

    // 5: reset in POST, then a clean capture
    trig_en = 1'b1;
    trig_pc = 16'd10;
    do_arm();
    feed(0, 11);
    chk("s5_state_post", {30'd0, state}, 32'd2);
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    chk("s5_state_idle", {30'd0, state}, 32'd0);
    scenario2(1'b0);

    // 6: trig_en=0 records continuously; sample_en low and arm in ARMED change nothing
    trig_en = 1'b0;
    do_arm();
    feed(0, 2);
    chk("s6_count3", {28'd0, count}, 32'd3);
    repeat (3) cyc();
    chk("s6_count_hold", {28'd0, count}, 32'd3);
    do_arm();
    chk("s6_arm_ignored_state", {30'd0, state}, 32'd1);
    chk("s6_arm_ignored_count", {28'd0, count}, 32'd3);
    feed(3, 12);
    chk("s6_count_sat", {28'd0, count}, 32'd8);
    chk("s6_still_armed", {30'd0, state}, 32'd1);
    chk("s6_not_triggered", {31'd0, triggered}, 32'd0);
    reset = 1'b1;
    cyc();
    reset = 1'b0;

    // 6b: identical samples held for four cycles
    do_arm();
    for (int k = 0; k < 4; k++) begin
      sample_en = 1'b1;
      pc = 16'd5; acc = 8'h3C; cy = 1'b0; z = 1'b0;
      cyc();
    end
    sample_en = 1'b0;
`ifdef TRACE_CHANGE_ONLY_EN
    chk("s6_same_samples", {28'd0, count}, 32'd1);
`else
    chk("s6_same_samples", {28'd0, count}, 32'd4);
`endif
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    cyc();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
